// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state encoding and default bus widths for the SRAM port arbiter
package sram_arb_pkg;
    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: client write/read handshakes plus the SRAM controller write/read ports
//   master: arbiter side (drives dones, rd_data, mem_* requests, busy)
//   slave : clients and SRAM controller side
interface sram_port_arbiter_if import sram_arb_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_done;
    logic              mem_w_request;
    logic [ADDR_W-1:0] mem_w_address;
    logic [DATA_W-1:0] mem_w_data;
    logic              mem_w_done;
    logic              mem_r_request;
    logic [ADDR_W-1:0] mem_r_address;
    logic [DATA_W-1:0] mem_r_data;
    logic              mem_r_done;
    logic              busy;
    modport master (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_w_done, mem_r_data, mem_r_done,
        output wr_done, rd_data, rd_done, mem_w_request, mem_w_address, mem_w_data,
               mem_r_request, mem_r_address, busy
    );
    modport slave (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_w_done, mem_r_data, mem_r_done,
        input  wr_done, rd_data, rd_done, mem_w_request, mem_w_address, mem_w_data,
               mem_r_request, mem_r_address, busy
    );
endinterface

// File: rtl/sram_arb_watchdog.sv
// sram_arb_watchdog: counts cycles spent in a memory transaction and flags a timeout
//   clk, reset: clock and synchronous active-high reset
//   active    : high while a transaction is outstanding (counter clears otherwise)
//   timeout   : high in the TIMEOUT_CYCLES-th cycle of an outstanding transaction
module sram_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    output logic timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d   = active ? cnt_q + 1'b1 : '0;
        timeout = active && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    end
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: arbitrates one write and one read client onto an SRAM controller, read-favoured with write anti-starvation
//   clk, reset: clock and synchronous active-high reset
//   bus       : client handshakes, SRAM controller ports and busy (sram_port_arbiter_if.master)
//   error     : sticky watchdog timeout flag, only with SRAM_ARB_WATCHDOG_EN defined
module sram_port_arbiter import sram_arb_pkg::*; #(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int READ_BURST_MAX = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
`ifdef SRAM_ARB_WATCHDOG_EN
    output logic error,
`endif
    sram_port_arbiter_if.master bus
);
    localparam int SW = $clog2(READ_BURST_MAX + 1);
    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              mem_w_req_q, mem_w_req_d, mem_r_req_q, mem_r_req_d;
    logic              wr_done_q, wr_done_d, rd_done_q, rd_done_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d, r_addr_q, r_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d, rd_data_q, rd_data_d;
    logic              accept, grant_w, grant_r, timeout;
`ifdef SRAM_ARB_WATCHDOG_EN
    logic error_q, error_d;
    sram_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk(clk), .reset(reset), .active(state_q != IDLE), .timeout(timeout)
    );
    assign error = error_q;
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        // the cycle a done pulse is out, requests are ignored so the client can drop its request
        accept      = state_q == IDLE && !wr_done_q && !rd_done_q;
        grant_w     = accept && bus.wr_req && (!bus.rd_req || starve_q == SW'(READ_BURST_MAX));
        grant_r     = accept && bus.rd_req && !grant_w;
        starve_d    = (grant_w || (state_q == IDLE && !bus.wr_req)) ? '0 :
                      (grant_r && starve_q != SW'(READ_BURST_MAX)) ? starve_q + 1'b1 : starve_q;
        state_d     = state_q;
        mem_w_req_d = mem_w_req_q;
        mem_r_req_d = mem_r_req_q;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        r_addr_d    = r_addr_q;
        rd_data_d   = rd_data_q;
        wr_done_d   = 1'b0;
        rd_done_d   = 1'b0;
        if (grant_w) begin
            state_d     = WRITE;
            mem_w_req_d = 1'b1;
            w_addr_d    = bus.wr_addr;
            w_data_d    = bus.wr_data;
        end
        if (grant_r) begin
            state_d     = READ;
            mem_r_req_d = 1'b1;
            r_addr_d    = bus.rd_addr;
        end
        if (state_q == WRITE && (bus.mem_w_done || timeout)) begin
            state_d     = IDLE;
            mem_w_req_d = 1'b0;
            wr_done_d   = 1'b1;
        end
        if (state_q == READ && (bus.mem_r_done || timeout)) begin
            state_d     = IDLE;
            mem_r_req_d = 1'b0;
            rd_done_d   = 1'b1;
            rd_data_d   = bus.mem_r_done ? bus.mem_r_data : rd_data_q;
        end
`ifdef SRAM_ARB_WATCHDOG_EN
        // a done arriving in the timeout cycle still counts as a normal completion
        error_d = error_q || (timeout && !(state_q == WRITE ? bus.mem_w_done : bus.mem_r_done));
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_w_req_q <= 1'b0;
            mem_r_req_q <= 1'b0;
            wr_done_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            r_addr_q    <= '0;
            rd_data_q   <= '0;
`ifdef SRAM_ARB_WATCHDOG_EN
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_w_req_q <= mem_w_req_d;
            mem_r_req_q <= mem_r_req_d;
            wr_done_q   <= wr_done_d;
            rd_done_q   <= rd_done_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            r_addr_q    <= r_addr_d;
            rd_data_q   <= rd_data_d;
`ifdef SRAM_ARB_WATCHDOG_EN
            error_q     <= error_d;
`endif
        end
    end
    assign bus.mem_w_request = mem_w_req_q;
    assign bus.mem_w_address = w_addr_q;
    assign bus.mem_w_data    = w_data_q;
    assign bus.mem_r_request = mem_r_req_q;
    assign bus.mem_r_address = r_addr_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.wr_done       = wr_done_q;
    assign bus.rd_done       = rd_done_q;
    assign bus.busy          = state_q != IDLE;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and randomized checks of sram_port_arbiter against a behavioural model
module tb_sram_port_arbiter;
    localparam int AW = 17;
    localparam int DW = 8;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef SRAM_ARB_WATCHDOG_EN
    logic error;
`endif
    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_BURST_MAX(BURST), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk),
        .reset(reset),
`ifdef SRAM_ARB_WATCHDOG_EN
        .error(error),
`endif
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] mem_model [int];
    int lat_min = 1;
    int lat_max = 1;
    bit mem_hold = 1'b0;

    // SRAM controller model: answers the active request after a random latency
    initial begin
        int cnt;
        int lat;
        int a;
        cnt = 0;
        lat = 1;
        bus.mem_w_done = 1'b0;
        bus.mem_r_done = 1'b0;
        bus.mem_r_data = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_w_done = 1'b0;
            bus.mem_r_done = 1'b0;
            bus.mem_r_data = DW'($urandom);
            if (!reset && !mem_hold && (bus.mem_w_request || bus.mem_r_request)) begin
                if (cnt == 0) lat = $urandom_range(lat_max, lat_min);
                cnt++;
                if (cnt >= lat) begin
                    cnt = 0;
                    if (bus.mem_w_request) begin
                        mem_model[int'(bus.mem_w_address)] = bus.mem_w_data;
                        bus.mem_w_done = 1'b1;
                    end else begin
                        a = int'(bus.mem_r_address);
                        if (!mem_model.exists(a)) mem_model[a] = DW'($urandom);
                        bus.mem_r_data = mem_model[a];
                        bus.mem_r_done = 1'b1;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic idle_clients();
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_clients();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_clients();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.mem_w_request, bus.mem_r_request, bus.wr_done, bus.rd_done, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {bus.mem_w_request, bus.mem_r_request, bus.wr_done, bus.rd_done, bus.busy});
        end
        checks++;
        if (bus.mem_w_address !== '0 || bus.mem_r_address !== '0) begin
            errors++;
            $display("FAIL reset_addr: got w=%h r=%h want 0", bus.mem_w_address, bus.mem_r_address);
        end
        checks++;
        if (bus.mem_w_data !== '0 || bus.rd_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got w=%h rd=%h want 0", bus.mem_w_data, bus.rd_data);
        end
`ifdef SRAM_ARB_WATCHDOG_EN
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL reset_error: got %b want 0", error);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_single_write();
        int done_at;
        int wd_at;
        bit held;
        lat_min = 3;
        lat_max = 3;
        done_at = -1;
        wd_at = -1;
        held = 1'b1;
        @(negedge clk);
        bus.wr_req = 1'b1;
        bus.wr_addr = 17'h00005;
        bus.wr_data = 8'hA5;
        @(negedge clk);
        checks++;
        if (bus.mem_w_request !== 1'b1 || bus.mem_w_address !== 17'h00005 || bus.mem_w_data !== 8'hA5) begin
            errors++;
            $display("FAIL write_issue: got req=%b addr=%h data=%h want 1 00005 a5", bus.mem_w_request, bus.mem_w_address, bus.mem_w_data);
        end
        for (int i = 1; i <= 12 && wd_at < 0; i++) begin
            @(negedge clk);
            if (bus.wr_done) begin
                wd_at = i;
                bus.wr_req = 1'b0;
                checks++;
                if (bus.busy !== 1'b0 || bus.mem_w_request !== 1'b0) begin
                    errors++;
                    $display("FAIL write_end_idle: got busy=%b req=%b want 0 0", bus.busy, bus.mem_w_request);
                end
            end else begin
                held &= bus.mem_w_request === 1'b1 && bus.mem_w_address === 17'h00005 && bus.mem_w_data === 8'hA5;
                if (bus.mem_w_done) done_at = i;
            end
        end
        checks++;
        if (done_at < 0 || wd_at != done_at + 1) begin
            errors++;
            $display("FAIL write_done_timing: got wr_done at %0d want %0d", wd_at, done_at + 1);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL write_hold: got request/address/data changing want stable");
        end
        @(negedge clk);
        checks++;
        if (bus.wr_done !== 1'b0) begin
            errors++;
            $display("FAIL write_pulse: got wr_done=%b second cycle want 0", bus.wr_done);
        end
    endtask

    task automatic test_single_read();
        bit w_seen;
        bit got;
        bit pre_ok;
        lat_min = 2;
        lat_max = 2;
        w_seen = 1'b0;
        got = 1'b0;
        pre_ok = 1'b1;
        mem_model[3] = 8'h3C;
        @(negedge clk);
        bus.rd_req = 1'b1;
        bus.rd_addr = 17'h00003;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            w_seen |= bus.mem_w_request;
            if (bus.rd_done) begin
                got = 1'b1;
                bus.rd_req = 1'b0;
                checks++;
                if (bus.rd_data !== 8'h3C) begin
                    errors++;
                    $display("FAIL read_data: got %h want 3c", bus.rd_data);
                end
            end else begin
                pre_ok &= bus.rd_data === 8'h00;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL read_done: got no rd_done want pulse");
        end
        checks++;
        if (!pre_ok) begin
            errors++;
            $display("FAIL read_early: got rd_data change before rd_done want 00 held");
        end
        repeat (3) begin
            @(negedge clk);
            w_seen |= bus.mem_w_request;
        end
        checks++;
        if (bus.rd_data !== 8'h3C) begin
            errors++;
            $display("FAIL read_hold: got %h want 3c", bus.rd_data);
        end
        checks++;
        if (w_seen) begin
            errors++;
            $display("FAIL read_no_write: got mem_w_request=1 want 0");
        end
    endtask

    task automatic test_contention();
        lat_min = 1;
        lat_max = 3;
        for (int round = 0; round < 2; round++) begin
            int reads;
            bit wgrant;
            bit wdone;
            bit pw;
            bit pr;
            reads = 0;
            wgrant = 1'b0;
            wdone = 1'b0;
            @(negedge clk);
            pw = bus.mem_w_request;
            pr = bus.mem_r_request;
            bus.wr_req = 1'b1;
            bus.wr_addr = AW'(17'h100 + round);
            bus.wr_data = 8'h5A;
            bus.rd_req = 1'b1;
            bus.rd_addr = AW'($urandom_range(0, 15));
            for (int i = 0; i < 200 && !wdone; i++) begin
                @(negedge clk);
                if (bus.mem_r_request && !pr && !wgrant) reads++;
                if (bus.mem_w_request && !pw) wgrant = 1'b1;
                if (bus.rd_done) bus.rd_addr = AW'($urandom_range(0, 15));
                if (bus.wr_done) begin
                    wdone = 1'b1;
                    bus.wr_req = 1'b0;
                end
                pw = bus.mem_w_request;
                pr = bus.mem_r_request;
            end
            checks++;
            if (!wdone || reads != BURST) begin
                errors++;
                $display("FAIL contention_round%0d: got %0d reads before write (write done=%b) want %0d", round, reads, wdone, BURST);
            end
        end
        for (int i = 0; i < 30 && bus.rd_req; i++) begin
            @(negedge clk);
            if (bus.rd_done) bus.rd_req = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int first;
        int rdone_at;
        int wgrant_at;
        bit wdone;
        bit pw;
        bit pr;
        first = 0;
        rdone_at = -1;
        wgrant_at = -1;
        wdone = 1'b0;
        lat_min = 1;
        lat_max = 2;
        @(negedge clk);
        pw = bus.mem_w_request;
        pr = bus.mem_r_request;
        bus.wr_req = 1'b1;
        bus.wr_addr = 17'h00020;
        bus.wr_data = 8'h77;
        bus.rd_req = 1'b1;
        bus.rd_addr = 17'h00021;
        for (int i = 0; i < 60 && !wdone; i++) begin
            @(negedge clk);
            if (first == 0 && bus.mem_r_request && !pr) first = 1;
            if (first == 0 && bus.mem_w_request && !pw) first = 2;
            if (bus.mem_w_request && !pw && wgrant_at < 0) wgrant_at = i;
            if (bus.rd_done) begin
                rdone_at = i;
                bus.rd_req = 1'b0;
            end
            if (bus.wr_done) begin
                wdone = 1'b1;
                bus.wr_req = 1'b0;
            end
            pw = bus.mem_w_request;
            pr = bus.mem_r_request;
        end
        checks++;
        if (first != 1) begin
            errors++;
            $display("FAIL simul_first: got grant kind %0d want 1 (read)", first);
        end
        checks++;
        if (rdone_at < 0 || wgrant_at <= rdone_at) begin
            errors++;
            $display("FAIL simul_order: got write grant at %0d rd_done at %0d want write after read", wgrant_at, rdone_at);
        end
        checks++;
        if (!wdone) begin
            errors++;
            $display("FAIL simul_write_done: got no wr_done want pulse");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        bit stray;
        seen = 1'b0;
        stray = 1'b0;
        mem_hold = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b1;
        bus.rd_addr = 17'h00007;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_r_request;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rstread_grant: got no mem_r_request want 1");
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_r_request !== 1'b0 || bus.busy !== 1'b0 || bus.rd_done !== 1'b0) begin
            errors++;
            $display("FAIL rstread_drop: got req=%b busy=%b rd_done=%b want 0 0 0", bus.mem_r_request, bus.busy, bus.rd_done);
        end
        reset = 1'b0;
        mem_hold = 1'b0;
        repeat (10) begin
            @(negedge clk);
            stray |= bus.rd_done | bus.mem_r_request;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL rstread_no_done: got rd_done or request after reset want none");
        end
    endtask

    task automatic test_random();
        bit w_act, r_act, pw, pr, sw, sr, gw, gr, exp_w, last_wd;
        int w_age, r_age, starve_ref;
        logic [AW-1:0] w_addr, r_addr;
        logic [DW-1:0] w_data, rd_exp;
        do_reset();
        w_act = 1'b0;
        r_act = 1'b0;
        pw = 1'b0;
        pr = 1'b0;
        last_wd = 1'b0;
        w_age = 0;
        r_age = 0;
        starve_ref = 0;
        rd_exp = '0;
        w_addr = '0;
        r_addr = '0;
        w_data = '0;
        lat_min = 1;
        lat_max = 4;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            sw = bus.wr_req;
            sr = bus.rd_req;
            checks++;
            if (bus.mem_w_request && bus.mem_r_request) begin
                errors++;
                $display("FAIL rnd_exclusive: got both requests high at cycle %0d want at most one", cyc);
            end
            checks++;
            if (bus.busy !== (bus.mem_w_request | bus.mem_r_request)) begin
                errors++;
                $display("FAIL rnd_busy: got %b want %b at cycle %0d", bus.busy, bus.mem_w_request | bus.mem_r_request, cyc);
            end
            gw = bus.mem_w_request && !pw;
            gr = bus.mem_r_request && !pr;
            if (gw || gr) begin
                exp_w = sw && (!sr || starve_ref == BURST);
                checks++;
                if (gw != exp_w || gr != (sr && !exp_w)) begin
                    errors++;
                    $display("FAIL rnd_grant: got w=%b r=%b want w=%b r=%b (wreq=%b rreq=%b reads_waited=%0d)", gw, gr, exp_w, sr && !exp_w, sw, sr, starve_ref);
                end
                checks++;
                if (gw ? (bus.mem_w_address !== w_addr || bus.mem_w_data !== w_data) : bus.mem_r_address !== r_addr) begin
                    errors++;
                    $display("FAIL rnd_payload: got w=%h/%h r=%h want w=%h/%h r=%h", bus.mem_w_address, bus.mem_w_data, bus.mem_r_address, w_addr, w_data, r_addr);
                end
                if (gw) starve_ref = 0;
                else if (sw && starve_ref < BURST) starve_ref++;
            end
            if (!sw) starve_ref = 0;
            checks++;
            if (bus.wr_done && last_wd) begin
                errors++;
                $display("FAIL rnd_wr_pulse: got wr_done high two cycles want one");
            end
            last_wd = bus.wr_done;
            if (bus.wr_done) begin
                checks++;
                if (!w_act || mem_model[int'(w_addr)] !== w_data) begin
                    errors++;
                    $display("FAIL rnd_write: got active=%b stored=%h want 1 %h", w_act, mem_model[int'(w_addr)], w_data);
                end
                w_act = 1'b0;
                bus.wr_req = 1'b0;
            end
            if (bus.rd_done) begin
                checks++;
                if (!r_act || bus.rd_data !== mem_model[int'(r_addr)]) begin
                    errors++;
                    $display("FAIL rnd_read: got active=%b data=%h want 1 %h", r_act, bus.rd_data, mem_model[int'(r_addr)]);
                end
                rd_exp = mem_model[int'(r_addr)];
                r_act = 1'b0;
                bus.rd_req = 1'b0;
            end else begin
                checks++;
                if (bus.rd_data !== rd_exp) begin
                    errors++;
                    $display("FAIL rnd_rd_hold: got %h want %h", bus.rd_data, rd_exp);
                end
            end
            if (w_act && ++w_age > 100) begin
                errors++;
                checks++;
                $display("FAIL rnd_write_timeout: got no wr_done in 100 cycles want done");
                w_age = -100000;
            end
            if (r_act && ++r_age > 100) begin
                errors++;
                checks++;
                $display("FAIL rnd_read_timeout: got no rd_done in 100 cycles want done");
                r_age = -100000;
            end
            if (cyc < 1400 && !w_act && $urandom_range(0, 3) == 0) begin
                w_act = 1'b1;
                w_age = 0;
                w_addr = AW'($urandom_range(0, 15));
                w_data = DW'($urandom);
                bus.wr_req = 1'b1;
                bus.wr_addr = w_addr;
                bus.wr_data = w_data;
            end
            if (cyc < 1400 && !r_act && $urandom_range(0, 1) == 0) begin
                r_act = 1'b1;
                r_age = 0;
                r_addr = AW'($urandom_range(0, 15));
                bus.rd_req = 1'b1;
                bus.rd_addr = r_addr;
            end
            pw = bus.mem_w_request;
            pr = bus.mem_r_request;
        end
        checks++;
        if (w_act || r_act) begin
            errors++;
            $display("FAIL rnd_drain: got outstanding w=%b r=%b want none", w_act, r_act);
        end
    endtask

`ifdef SRAM_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        bit seen;
        do_reset();
        mem_hold = 1'b1;
        n = -1;
        seen = 1'b0;
        @(negedge clk);
        bus.wr_req = 1'b1;
        bus.wr_addr = 17'h00009;
        bus.wr_data = 8'h11;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_w_request;
        end
        for (int i = 1; i <= 100 && n < 0; i++) begin
            @(negedge clk);
            if (bus.wr_done) begin
                n = i;
                bus.wr_req = 1'b0;
            end
        end
        checks++;
        if (!seen || n != 64) begin
            errors++;
            $display("FAIL wdog_timing: got wr_done after %0d cycles want 64", n);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (error !== 1'b1 || bus.mem_w_request !== 1'b0) begin
            errors++;
            $display("FAIL wdog_sticky: got error=%b req=%b want 1 0", error, bus.mem_w_request);
        end
        mem_hold = 1'b0;
        do_reset();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL wdog_clear: got error=%b want 0", error);
        end
    endtask
`else
    task automatic test_no_watchdog();
        bit early;
        early = 1'b0;
        do_reset();
        mem_hold = 1'b1;
        @(negedge clk);
        bus.wr_req = 1'b1;
        bus.wr_addr = 17'h00009;
        bus.wr_data = 8'h11;
        repeat (100) begin
            @(negedge clk);
            early |= bus.wr_done | !bus.mem_w_request;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL nowdog_wait: got wr_done or dropped request want indefinite wait");
        end
        mem_hold = 1'b0;
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_simultaneous();
        test_reset_mid_read();
        test_random();
`ifdef SRAM_ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
